axi_master: RTL and testbench
=============================

Name: axi_master

Overview:
- AXI4 initiator: the requester-side counterpart to the team's AXI4 slave.
- Accepts a single-command request from a local engine and drives one AXI4 read or write burst on an axi_if.master port.
- Streams write beats in from a local source and read beats out to a local sink.
- Exactly one transaction is outstanding at a time. Sits between DMA/test engines and the AXI slave fabric.

Parameters:
- MAX_LEN, 8'd255: largest accepted cmd_len (beats-1). Larger values are clamped to MAX_LEN.
- DEF_SIZE, 3'b010: value driven on arsize/awsize (4-byte beats, matching data_t).

Ports:
- aclk  input  1  clock; all logic on rising edge
- areset  input  1  asynchronous, active-high reset
- m_axi  interface  axi_if.master  AXI4 AR/R/AW/W/B channels (addr_t, data_t, len_t, size_t, burst_t from axi_pkg)
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE
- cmd_write  input  1  1=write burst, 0=read burst
- cmd_addr  input  addr_t  burst start address
- cmd_len  input  len_t  beats minus one
- cmd_burst  input  burst_t  FIXED/INCR/WRAP, passed through unchecked
- wr_data  input  data_t  write beat from local source
- wr_valid  input  1  write beat available
- wr_ready  output  1  write beat consumed
- rd_data  output  data_t  read beat to local sink
- rd_valid  output  1  read beat valid
- rd_ready  input  1  sink can take beat
- rd_last  output  1  final read beat
- done  output  1  one-cycle pulse at burst completion
- done_resp  output  2  bresp (write) or worst rresp (read); valid with done

Behaviour:
- Reset (async assert, sync deassert): state=IDLE.
  - Reset values: arvalid, awvalid, wvalid, wlast, rready, bready, wr_ready, rd_valid, done = 0; cmd_ready = 0 while areset high.
  - All address/len/burst/data regs = 0. Reset mid-burst drops the transaction immediately; no completion or done is produced.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr/len/burst, clear beat_cnt, clear resp accumulator. Next state is WADDR if cmd_write, else RADDR.
- RADDR/WADDR: arvalid/awvalid registered, asserted the first cycle after command acceptance. Held with stable araddr/arlen/arsize/arburst (aw*) until arready/awready sampled high. Next state RDATA/WDATA. Address handshake must not occur in the acceptance cycle itself.
- WDATA: one-entry holding register (wbuf, wfull).
  - wr_ready = (state==WDATA) && (!wfull || m_axi.wready) && (beats_taken <= len).
  - wvalid = wfull; wdata = wbuf; wlast = wfull && (beat_cnt == len).
  - Once wvalid is high it stays high and wdata is stable until wready.
  - On wvalid&&wready: beat_cnt++. A new beat may load in the same cycle (zero-bubble).
  - Exit to WRESP on wvalid&&wready&&wlast. No beats are taken beyond len+1.
- WRESP: bready=1. On bvalid: done=1 next cycle, done_resp=bresp, state=IDLE.
- RDATA: rready = rd_ready, with rd_valid = rvalid, rd_data = rdata, rd_last = rlast (combinational pass-through gated by state==RDATA).
  - On rvalid&&rready: beat_cnt++; resp accumulator keeps the max of rresp (SLVERR/DECERR dominate OKAY).
  - Exit on the handshake with beat_cnt==len. rlast is not trusted for termination.
  - Then done=1 next cycle, done_resp = accumulated resp.
- len==0: a single beat; wlast is asserted on the first W beat.
- beat_cnt is 9 bits and never wraps within a burst.
- Back-to-back: the command after done is accepted no earlier than the cycle done is high (IDLE).

Optional Feature:
- Macro: AXI_MASTER_LAST_CHECK_EN.
  - Defined: adds output last_err (1 bit, sticky, cleared only by reset). Set when rlast=1 on a non-final beat, or rlast=0 on the beat where beat_cnt==len. Termination still follows beat_cnt.
  - Undefined: no last_err port; rlast is only forwarded to rd_last.

Test Plan:
- Reset: areset high mid-WDATA -> all valids 0 same cycle; state IDLE; cmd_ready=1 after deassert; no done.
- Write INCR, addr=0, len=3, data 0xA0..0xA3, slave wready always 1 -> awvalid 1 cycle after accept; 4 W beats; wlast only on 0xA3; done with done_resp=OKAY.
- Write with wready toggling 1010 and wr_valid gaps -> wvalid never drops before handshake; wdata stable while stalled; exactly 4 beats issued.
- Read INCR, addr=2, len=1, rd_ready held low 3 cycles -> rready=0 during stall; rd_data sequence preserved; done after 2nd beat.
- Read len=0 with rresp=SLVERR -> single beat; done_resp=2'b10.
- Read len=3 where slave asserts rlast on beat 2 (AXI_MASTER_LAST_CHECK_EN defined) -> last_err=1, burst still completes after beat 4; without macro -> completes identically.

Source files
------------

// File: rtl/axi_master_if.sv
// AXI4 type package and channel bundle shared by initiators and targets.
// Latency: none (type definitions and wires only).
// Backpressure: carried per channel by the usual valid/ready pairs.
//
// axi_pkg : addr_t, data_t, len_t, size_t, burst_t, resp_t and burst/resp codes.
// axi_if  : AR/R/AW/W/B channel signals with master and slave modports.

package axi_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [7:0]  len_t;
    typedef logic [2:0]  size_t;
    typedef logic [1:0]  burst_t;
    typedef logic [1:0]  resp_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;
endpackage

interface axi_if;
    import axi_pkg::*;

    // read address
    addr_t  araddr;
    len_t   arlen;
    size_t  arsize;
    burst_t arburst;
    logic   arvalid;
    logic   arready;
    // read data
    data_t  rdata;
    resp_t  rresp;
    logic   rlast;
    logic   rvalid;
    logic   rready;
    // write address
    addr_t  awaddr;
    len_t   awlen;
    size_t  awsize;
    burst_t awburst;
    logic   awvalid;
    logic   awready;
    // write data
    data_t  wdata;
    logic [3:0] wstrb;
    logic   wlast;
    logic   wvalid;
    logic   wready;
    // write response
    resp_t  bresp;
    logic   bvalid;
    logic   bready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_master.sv
// Single-outstanding AXI4 initiator: one local command -> one AXI read or write burst.
// Latency: AR/AW valid 1 cycle after accept; W path has a 1-entry buffer; done 1 cycle after last R / B.
// Backpressure: wr_ready follows W buffer space, rready follows rd_ready, cmd_ready only when idle.
//
// Ports: aclk/areset (async active-high); m_axi (axi_if.master);
//        cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len/cmd_burst command in;
//        wr_data/wr_valid/wr_ready write beats in; rd_data/rd_valid/rd_ready/rd_last read beats out;
//        done/done_resp completion pulse with bresp or worst rresp.
// Optional: define AXI_MASTER_LAST_CHECK_EN to add the sticky last_err output that flags
//           rlast disagreeing with the beat count.

module axi_master
    import axi_pkg::*;
#(
    parameter len_t  MAX_LEN  = 8'd255,
    parameter size_t DEF_SIZE = 3'b010
) (
    input  logic        aclk,
    input  logic        areset,
    axi_if.master       m_axi,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  addr_t       cmd_addr,
    input  len_t        cmd_len,
    input  burst_t      cmd_burst,
    input  data_t       wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output data_t       rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        rd_last,
    output logic        done,
    output resp_t       done_resp
`ifdef AXI_MASTER_LAST_CHECK_EN
    ,
    output logic        last_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WDATA,
        WRESP
    } state_t;

    state_t     state;
    addr_t      addr_q;
    len_t       len_q;
    burst_t     burst_q;
    logic [8:0] beat_cnt;     // beats handshaken on the AXI side
    logic [8:0] beats_taken;  // beats pulled from the local write source
    resp_t      resp_acc;
    data_t      wbuf;
    logic       wfull;
    logic       arvalid_q;
    logic       awvalid_q;

    logic [8:0] len_ext;
    logic       at_last;
    logic       w_hs;
    logic       w_load;
    logic       r_hs;

    function automatic resp_t resp_max(input resp_t a, input resp_t b);
        return (a > b) ? a : b;
    endfunction

    assign len_ext = {1'b0, len_q};
    assign at_last = (beat_cnt == len_ext);

    assign cmd_ready = (state == IDLE) && !areset;

    // Address channels
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = DEF_SIZE;
    assign m_axi.arburst = burst_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = DEF_SIZE;
    assign m_axi.awburst = burst_q;
    assign m_axi.awvalid = awvalid_q;

    // Write data: wbuf is the only thing ever presented, so wvalid/wdata stay
    // stable until wready. A new beat may refill it in the draining cycle, and
    // the source is cut off once len+1 beats have been pulled.
    assign w_hs          = wfull && m_axi.wready;
    assign wr_ready      = (state == WDATA) && (!wfull || m_axi.wready) && (beats_taken <= len_ext);
    assign w_load        = wr_valid && wr_ready;
    assign m_axi.wvalid  = wfull;
    assign m_axi.wdata   = wbuf;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wlast   = wfull && at_last;

    assign m_axi.bready  = (state == WRESP);

    // Read data is a straight pass-through while a read burst is active.
    assign m_axi.rready  = (state == RDATA) && rd_ready;
    assign rd_valid      = (state == RDATA) && m_axi.rvalid;
    assign rd_data       = (state == RDATA) ? m_axi.rdata : '0;
    assign rd_last       = (state == RDATA) && m_axi.rlast;
    assign r_hs          = (state == RDATA) && m_axi.rvalid && rd_ready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            beat_cnt    <= '0;
            beats_taken <= '0;
            resp_acc    <= '0;
            wbuf        <= '0;
            wfull       <= 1'b0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            done        <= 1'b0;
            done_resp   <= '0;
`ifdef AXI_MASTER_LAST_CHECK_EN
            last_err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        len_q       <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
                        burst_q     <= cmd_burst;
                        beat_cnt    <= '0;
                        beats_taken <= '0;
                        resp_acc    <= '0;
                        wfull       <= 1'b0;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            state     <= WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= RDATA;
                    end
                end
                WADDR: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        state     <= WDATA;
                    end
                end
                WDATA: begin
                    if (w_load) begin
                        wbuf        <= wr_data;
                        beats_taken <= beats_taken + 9'd1;
                    end
                    if (w_load) begin
                        wfull <= 1'b1;
                    end else if (w_hs) begin
                        wfull <= 1'b0;
                    end
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (at_last) begin
                            state <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (m_axi.bvalid) begin
                        done      <= 1'b1;
                        done_resp <= m_axi.bresp;
                        state     <= IDLE;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        resp_acc <= resp_max(resp_acc, m_axi.rresp);
`ifdef AXI_MASTER_LAST_CHECK_EN
                        if (m_axi.rlast != at_last) begin
                            last_err <= 1'b1;
                        end
`endif
                        // Termination is by beat count; rlast is only forwarded.
                        if (at_last) begin
                            done      <= 1'b1;
                            done_resp <= resp_max(resp_acc, m_axi.rresp);
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master.sv
// Randomized bench for axi_master with a behavioural AXI target and local source/sink.
// Latency: checks AR/AW one cycle after accept and done one cycle after the final R/B handshake.
// Backpressure: random and patterned wready/rd_ready/arready/awready plus source gaps.

module tb_axi_master;
    import axi_pkg::*;

    localparam len_t TB_MAX_LEN = 8'd15;

    logic   aclk;
    logic   areset;
    logic   cmd_valid;
    logic   cmd_ready;
    logic   cmd_write;
    addr_t  cmd_addr;
    len_t   cmd_len;
    burst_t cmd_burst;
    data_t  wr_data;
    logic   wr_valid;
    logic   wr_ready;
    data_t  rd_data;
    logic   rd_valid;
    logic   rd_ready;
    logic   rd_last;
    logic   done;
    resp_t  done_resp;
`ifdef AXI_MASTER_LAST_CHECK_EN
    logic   last_err;
    bit     exp_lerr;
`endif

    int n_chk;
    int n_err;

    axi_if bus ();

    axi_master #(.MAX_LEN(TB_MAX_LEN), .DEF_SIZE(3'b010)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .m_axi     (bus),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_burst (cmd_burst),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_last   (rd_last),
        .done      (done),
        .done_resp (done_resp)
`ifdef AXI_MASTER_LAST_CHECK_EN
        ,
        .last_err  (last_err)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_len(input len_t l);
        return (l > TB_MAX_LEN) ? int'(TB_MAX_LEN) : int'(l);
    endfunction

    // mode 0: target/source always ready, data A0.. ; 1: wready 1010 with source gaps; 2: random
    task automatic run_write(input addr_t addr, input len_t clen, input burst_t burst,
                             input int mode, input resp_t bresp_v);
        int    eff, src_idx, beat, cyc, b_wait;
        data_t wq[$];
        data_t prev_wdata;
        bit    aw_done, w_done, b_done, pend, exp_done, got_done, prev_stall;
        eff = clamp_len(clen);
        src_idx = 0; beat = 0; cyc = 0; b_wait = 0;
        aw_done = 0; w_done = 0; b_done = 0; pend = 0; got_done = 0; prev_stall = 0;
        prev_wdata = '0;
        for (int i = 0; i <= eff; i++) wq.push_back((mode == 0) ? 32'hA0 + i : $urandom());

        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = clen; cmd_burst = burst;
        #1;
        check("w_cmd_ready", cmd_ready, 1);
        check("aw_not_in_accept", bus.awvalid, 0);
        while (!got_done && cyc < 400) begin
            @(negedge aclk);
            cmd_valid = 1'b0; cmd_addr = $urandom(); cmd_len = 8'($urandom());
            bus.awready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (mode)
                0:       bus.wready = 1'b1;
                1:       bus.wready = (cyc % 2 == 0);
                default: bus.wready = 1'($urandom_range(0, 1));
            endcase
            wr_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
            wr_data  = (src_idx <= eff) ? wq[src_idx] : 32'hDEAD0000 + src_idx;
            if (w_done && !b_done) begin
                if (b_wait > 0) b_wait--;
                else begin
                    bus.bvalid = 1'b1;
                    bus.bresp  = bresp_v;
                end
            end else begin
                bus.bvalid = 1'b0;
            end
            #1;
            exp_done = pend; pend = 0;
            if (cyc == 0) check("awvalid_first", bus.awvalid, 1);
            if (aw_done) check("aw_once", bus.awvalid, 0);
            if (bus.awvalid && bus.awready) begin
                check("awaddr", bus.awaddr, addr);
                check("awlen", bus.awlen, eff);
                check("awsize", bus.awsize, 3'b010);
                check("awburst", bus.awburst, burst);
                aw_done = 1;
            end
            if (prev_stall) begin
                check("wvalid_hold", bus.wvalid, 1);
                check("wdata_hold", bus.wdata, prev_wdata);
            end
            prev_stall = bus.wvalid && !bus.wready;
            prev_wdata = bus.wdata;
            if (bus.wvalid && bus.wready) begin
                if (beat > eff) check("w_extra_beat", beat, eff);
                else begin
                    check("wdata", bus.wdata, wq[beat]);
                    check("wlast", bus.wlast, beat == eff);
                end
                beat++;
                if (beat == eff + 1) begin
                    w_done = 1;
                    b_wait = $urandom_range(0, 3);
                end
            end
            if (wr_valid && wr_ready) src_idx++;
            if (bus.bvalid && bus.bready) begin
                b_done = 1;
                pend   = 1;
            end
            if (done || exp_done) begin
                check("w_done_pulse", done, exp_done);
                if (done) begin
                    check("w_done_resp", done_resp, bresp_v);
                    check("cmd_ready_at_done", cmd_ready, 1);
                    got_done = 1;
                end
            end
            cyc++;
        end
        check("write_finished", got_done, 1);
        check("w_beats", beat, eff + 1);
        check("src_taken", src_idx, eff + 1);
        bus.bvalid = 1'b0; bus.wready = 1'b0; wr_valid = 1'b0;
    endtask

    // mode 0: random handshakes; 1: rvalid steady, rd_ready low 3 cycles after AR
    task automatic run_read(input addr_t addr, input len_t clen, input burst_t burst,
                            input int mode, input int bad_pos, input int fixed_resp);
        int    eff, sidx, cyc, data_cyc;
        data_t rq[$];
        resp_t sq[$];
        resp_t exp_resp, r;
        bit    ar_done, r_pend, pend, exp_done, got_done;
        eff = clamp_len(clen);
        sidx = 0; cyc = 0; data_cyc = 0;
        ar_done = 0; r_pend = 0; pend = 0; got_done = 0;
        exp_resp = RESP_OKAY;
        for (int i = 0; i <= eff; i++) begin
            rq.push_back($urandom());
            r = (fixed_resp >= 0) ? 2'(fixed_resp) : 2'($urandom_range(0, 3));
            sq.push_back(r);
            if (r > exp_resp) exp_resp = r;
        end

        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = clen; cmd_burst = burst;
        #1;
        check("r_cmd_ready", cmd_ready, 1);
        check("ar_not_in_accept", bus.arvalid, 0);
        while (!got_done && cyc < 400) begin
            @(negedge aclk);
            cmd_valid = 1'b0; cmd_addr = $urandom(); cmd_len = 8'($urandom());
            bus.arready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            rd_ready = (mode == 1) ? (ar_done && data_cyc >= 3) : ($urandom_range(0, 3) != 0);
            if (ar_done && sidx <= eff && !r_pend)
                r_pend = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.rvalid = r_pend;
            if (r_pend) begin
                bus.rdata = rq[sidx];
                bus.rresp = sq[sidx];
                bus.rlast = (bad_pos >= 0) ? (sidx == bad_pos) : (sidx == eff);
            end else begin
                bus.rdata = $urandom();
                bus.rresp = 2'($urandom());
                bus.rlast = 1'($urandom());
            end
            #1;
            exp_done = pend; pend = 0;
            if (cyc == 0) check("arvalid_first", bus.arvalid, 1);
            if (ar_done) check("ar_once", bus.arvalid, 0);
            if (ar_done && sidx <= eff) begin
                check("rready_follows", bus.rready, rd_ready);
                check("rd_valid", rd_valid, bus.rvalid);
            end else begin
                check("rready_idle", bus.rready, 0);
            end
            if (bus.arvalid && bus.arready) begin
                check("araddr", bus.araddr, addr);
                check("arlen", bus.arlen, eff);
                check("arsize", bus.arsize, 3'b010);
                check("arburst", bus.arburst, burst);
                ar_done = 1;
            end else if (ar_done) begin
                data_cyc++;
            end
            if (bus.rvalid && bus.rready) begin
                if (sidx > eff) check("r_extra_beat", sidx, eff);
                else begin
                    check("rd_data", rd_data, rq[sidx]);
                    check("rd_last", rd_last, bus.rlast);
`ifdef AXI_MASTER_LAST_CHECK_EN
                    if (bus.rlast != (sidx == eff)) exp_lerr = 1;
`endif
                    if (sidx == eff) pend = 1;
                end
                sidx++;
                r_pend = 0;
            end
            if (done || exp_done) begin
                check("r_done_pulse", done, exp_done);
                if (done) begin
                    check("r_done_resp", done_resp, exp_resp);
                    check("cmd_ready_at_done", cmd_ready, 1);
                    got_done = 1;
                end
            end
            cyc++;
        end
        check("read_finished", got_done, 1);
        check("r_beats", sidx, eff + 1);
`ifdef AXI_MASTER_LAST_CHECK_EN
        check("last_err", last_err, exp_lerr);
`endif
        bus.rvalid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string pfx, input logic exp_cmd_ready);
        check({pfx, "_arvalid"}, bus.arvalid, 0);
        check({pfx, "_awvalid"}, bus.awvalid, 0);
        check({pfx, "_wvalid"}, bus.wvalid, 0);
        check({pfx, "_wlast"}, bus.wlast, 0);
        check({pfx, "_rready"}, bus.rready, 0);
        check({pfx, "_bready"}, bus.bready, 0);
        check({pfx, "_wr_ready"}, wr_ready, 0);
        check({pfx, "_rd_valid"}, rd_valid, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_cmd_ready"}, cmd_ready, exp_cmd_ready);
    endtask

    task automatic run_reset_mid_write();
        bit saw_done;
        saw_done = 0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 8'd3; cmd_burst = BURST_INCR;
        bus.awready = 1'b1; bus.wready = 1'b0; wr_valid = 1'b1; wr_data = 32'h5A5A0000;
        @(negedge aclk);
        cmd_valid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        check("mid_wvalid", bus.wvalid, 1);
        areset = 1'b1;
        #1;
        check_idle_outputs("rst_mid", 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0; wr_valid = 1'b0; bus.awready = 1'b0;
        #1;
        check("cmd_ready_after_rst", cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            #1;
            if (done) saw_done = 1;
        end
        check("no_done_after_rst", saw_done, 0);
        check("wvalid_after_rst", bus.wvalid, 0);
`ifdef AXI_MASTER_LAST_CHECK_EN
        exp_lerr = 0;
        check("last_err_rst", last_err, 0);
`endif
    endtask

    addr_t  r_addr;
    len_t   r_len;
    burst_t r_burst;

    initial begin
        n_chk = 0; n_err = 0;
`ifdef AXI_MASTER_LAST_CHECK_EN
        exp_lerr = 0;
`endif
        areset = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_burst = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0;
        bus.arready = 0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bresp = '0; bus.bvalid = 0;

        @(negedge aclk);
        #1;
        check_idle_outputs("reset", 1'b0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);

        run_write(32'h0, 8'd3, BURST_INCR, 0, RESP_OKAY);
        run_write(32'h100, 8'd3, BURST_INCR, 1, RESP_OKAY);
        run_read(32'h2, 8'd1, BURST_INCR, 1, -1, 0);
        run_read(32'h40, 8'd0, BURST_INCR, 0, -1, 2);
        run_read(32'h80, 8'd3, BURST_INCR, 0, 1, 0);
        run_write(32'h300, 8'd20, BURST_WRAP, 2, RESP_DECERR);
        run_write(32'h10, 8'd0, BURST_FIXED, 2, RESP_SLVERR);
        run_read(32'h400, 8'd200, BURST_FIXED, 0, -1, -1);
        run_reset_mid_write();

        for (int t = 0; t < 24; t++) begin
            r_addr  = $urandom();
            r_len   = 8'($urandom_range(0, 20));
            r_burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1)
                run_write(r_addr, r_len, r_burst, 2, 2'($urandom()));
            else
                run_read(r_addr, r_len, r_burst, 0,
                         ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, clamp_len(r_len))) : -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
